// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined core: opcodes, the NOP word,
// the fetch FSM state encoding and an opcode-field helper.
package cpu_pkg;

    // Instruction opcodes, held in the top five bits of every word.
    localparam logic [4:0] OP_LV   = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_MUL  = 5'd4;
    localparam logic [4:0] OP_X    = 5'd5;
    localparam logic [4:0] OP_CP   = 5'd6;
    localparam logic [4:0] OP_B    = 5'd7;
    localparam logic [4:0] OP_BEQ  = 5'd8;
    localparam logic [4:0] OP_SLR  = 5'd9;
    localparam logic [4:0] OP_GP   = 5'd10;
    localparam logic [4:0] OP_HALT = 5'd31;

    // Word presented to decode when nothing valid is available.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Position of the opcode field inside an instruction word.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,  // no request outstanding
        FS_WAIT   = 2'd1,  // request outstanding, response will be used
        FS_SQUASH = 2'd2,  // request outstanding, response will be dropped
        FS_HALT   = 2'd3   // HALT fetched, no further requests
    } fetch_state_t;

    // Extract the opcode field of an instruction word.
    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, reads instruction
// memory through a single-outstanding req/valid handshake and presents one
// instruction at a time to decode. A one-entry skid register absorbs the
// response that lands while decode is stalled, redirects squash wrong-path
// work, and a HALT opcode parks the unit until the next redirect or reset.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_valid,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [31:0]         Instruccion,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                halted
);

    fetch_state_t        state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;

    // Output register seen by decode.
    logic [31:0]         out_instr_reg, out_instr_next;
    logic [PC_WIDTH-1:0] out_pc_reg, out_pc_next;
    logic                out_valid_reg, out_valid_next;

    // Skid register holding a response that arrived while decode stalled.
    logic [31:0]         skid_instr_reg, skid_instr_next;
    logic [PC_WIDTH-1:0] skid_pc_reg, skid_pc_next;
    logic                skid_valid_reg, skid_valid_next;

    logic                out_free;
    logic                rsp_is_halt;
    logic                req_issue;
    logic                req_at_next_pc;

    // The output register can take a new word when empty or being consumed.
    assign out_free    = !out_valid_reg || !stall;
    assign rsp_is_halt = (opcode_of(imem_rdata) == OP_HALT);

    // Next-state logic: redirect first, then per-state fetch behaviour.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        out_instr_next  = out_instr_reg;
        out_pc_next     = out_pc_reg;
        out_valid_next  = out_valid_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        skid_valid_next = skid_valid_reg;
        req_issue       = 1'b0;
        req_at_next_pc  = 1'b0;

        if (redirect) begin
            // Flush everything on the wrong path and restart at the target.
            out_valid_next  = 1'b0;
            out_instr_next  = NOP_INSTR;
            skid_valid_next = 1'b0;
            pc_next         = redirect_pc;
            // A response still in flight must be swallowed before refetching;
            // one arriving right now is simply dropped.
            if ((state_reg == FS_WAIT || state_reg == FS_SQUASH) && !imem_valid) begin
                state_next = FS_SQUASH;
            end else begin
                state_next = FS_IDLE;
            end
        end else begin
            case (state_reg)
                FS_IDLE: begin
                    if (out_free) begin
                        if (skid_valid_reg) begin
                            out_instr_next  = skid_instr_reg;
                            out_pc_next     = skid_pc_reg;
                            out_valid_next  = 1'b1;
                            skid_valid_next = 1'b0;
                        end else if (out_valid_reg) begin
                            out_valid_next = 1'b0;
                            out_instr_next = NOP_INSTR;
                        end
                        req_issue  = 1'b1;
                        state_next = FS_WAIT;
                    end
                end

                FS_WAIT: begin
                    if (imem_valid) begin
                        pc_next = pc_reg + 1'b1;
                        if (out_free) begin
                            out_instr_next = imem_rdata;
                            out_pc_next    = pc_reg;
                            out_valid_next = 1'b1;
                            if (rsp_is_halt) begin
                                state_next = FS_HALT;
                            end else begin
                                // Back-to-back: request the following word now.
                                req_issue      = 1'b1;
                                req_at_next_pc = 1'b1;
                            end
                        end else begin
                            skid_instr_next = imem_rdata;
                            skid_pc_next    = pc_reg;
                            skid_valid_next = 1'b1;
                            state_next      = rsp_is_halt ? FS_HALT : FS_IDLE;
                        end
                    end else if (out_valid_reg && !stall) begin
                        out_valid_next = 1'b0;
                        out_instr_next = NOP_INSTR;
                    end
                end

                FS_SQUASH: begin
                    // Output was flushed by the redirect; only drop the response.
                    if (imem_valid) begin
                        state_next = FS_IDLE;
                    end
                end

                FS_HALT: begin
                    // Drain whatever is left (possibly the HALT word in the skid).
                    if (out_free) begin
                        if (skid_valid_reg) begin
                            out_instr_next  = skid_instr_reg;
                            out_pc_next     = skid_pc_reg;
                            out_valid_next  = 1'b1;
                            skid_valid_next = 1'b0;
                        end else if (out_valid_reg) begin
                            out_valid_next = 1'b0;
                            out_instr_next = NOP_INSTR;
                        end
                    end
                end

                default: begin
                    state_next = FS_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= FS_IDLE;
            pc_reg         <= RESET_PC;
            out_instr_reg  <= NOP_INSTR;
            out_pc_reg     <= '0;
            out_valid_reg  <= 1'b0;
            skid_instr_reg <= NOP_INSTR;
            skid_pc_reg    <= '0;
            skid_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            out_instr_reg  <= out_instr_next;
            out_pc_reg     <= out_pc_next;
            out_valid_reg  <= out_valid_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    // The address equals pc while a request waits, so it stays stable until
    // the response; only a back-to-back request looks one word ahead.
    assign imem_req    = req_issue && !reset;
    assign imem_addr   = (req_at_next_pc && !reset) ? (pc_reg + 1'b1) : pc_reg;
    assign Instruccion = out_instr_reg;
    assign instr_valid = out_valid_reg;
    assign instr_pc    = out_pc_reg;
    assign halted      = (state_reg == FS_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the expected consumed
// instructions into a queue, a negedge monitor pops and compares them each
// time decode consumes one, and directed checks cover reset, stall, squash,
// HALT and PC wrap (second instance with a 4-bit PC).
module tb_fetch_unit;
    import cpu_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- main instance (PC_WIDTH = 10) ----------------
    logic        reset, stall, redirect, imem_valid;
    logic [9:0]  redirect_pc;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, halted;
    logic [9:0]  imem_addr, instr_pc;
    logic [31:0] Instruccion;

    fetch_unit #(.PC_WIDTH(10), .RESET_PC(10'd0)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .Instruccion(Instruccion), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .halted(halted)
    );

    // ---------------- small instance (PC_WIDTH = 4, start 14) ----------------
    logic        reset2, stall2, redirect2, imem_valid2;
    logic [3:0]  redirect_pc2;
    logic [31:0] imem_rdata2;
    logic        imem_req2, instr_valid2, halted2;
    logic [3:0]  imem_addr2, instr_pc2;
    logic [31:0] Instruccion2;

    fetch_unit #(.PC_WIDTH(4), .RESET_PC(4'd14)) dut2 (
        .clock(clock), .reset(reset2),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .imem_valid(imem_valid2),
        .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .Instruccion(Instruccion2), .instr_valid(instr_valid2),
        .instr_pc(instr_pc2), .halted(halted2)
    );

    localparam logic [31:0] HALT_WORD = 32'hF800_0000;

    logic [31:0] mem  [0:1023];
    logic [31:0] mem2 [0:15];
    int lat = 1;

    typedef struct packed {
        logic [9:0]  pc;
        logic [31:0] word;
    } exp_t;
    exp_t exp_q[$];
    exp_t exp2_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [9:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc = pc;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic push_exp2(input logic [9:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc = pc;
        e.word = word;
        exp2_q.push_back(e);
    endtask

    // Main memory model: one outstanding read, response after lat cycles.
    initial begin
        int cnt;
        logic [9:0] paddr;
        logic req_s;
        logic [9:0] addr_s;
        cnt = 0;
        paddr = '0;
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clock);
            req_s = imem_req;
            addr_s = imem_addr;
            #1;
            if (req_s) begin
                paddr = addr_s;
                cnt = lat;
            end else if (cnt > 0) begin
                cnt--;
            end
            imem_valid = (cnt == 1);
            imem_rdata = (cnt == 1) ? mem[paddr] : 32'hDEAD_BEEF;
        end
    end

    // Small-instance memory model, fixed 1-cycle latency.
    initial begin
        int cnt;
        logic [3:0] paddr;
        logic req_s;
        logic [3:0] addr_s;
        cnt = 0;
        paddr = '0;
        imem_valid2 = 1'b0;
        imem_rdata2 = 32'hDEAD_BEEF;
        forever begin
            @(posedge clock);
            req_s = imem_req2;
            addr_s = imem_addr2;
            #1;
            if (req_s) begin
                paddr = addr_s;
                cnt = 1;
            end else if (cnt > 0) begin
                cnt--;
            end
            imem_valid2 = (cnt == 1);
            imem_rdata2 = (cnt == 1) ? mem2[paddr] : 32'hDEAD_BEEF;
        end
    end

    // Main monitor: scoreboard pops on consumption, NOP and stall-hold checks.
    initial begin
        exp_t e;
        logic p_valid, p_stall, p_redirect, p_reset;
        logic [31:0] p_instr;
        logic [9:0] p_pc;
        p_valid = 0; p_stall = 0; p_redirect = 0; p_reset = 1;
        p_instr = '0; p_pc = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (instr_valid && !stall && !redirect) begin
                    $display("[%0t] consume pc=%03h word=%08h", $time, instr_pc, Instruccion);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr: got pc=%03h word=%08h expected none", instr_pc, Instruccion);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_pc", 32'(instr_pc), 32'(e.pc));
                        check("instr_word", Instruccion, e.word);
                    end
                end
                if (!instr_valid) check("nop_when_invalid", Instruccion, NOP_INSTR);
                if (p_valid && p_stall && !p_redirect && !p_reset) begin
                    check("stall_hold_valid", 32'(instr_valid), 32'(p_valid));
                    check("stall_hold_pc", 32'(instr_pc), 32'(p_pc));
                    check("stall_hold_word", Instruccion, p_instr);
                end
            end
            p_valid = instr_valid; p_stall = stall; p_redirect = redirect;
            p_reset = reset; p_instr = Instruccion; p_pc = instr_pc;
        end
    end

    // Small-instance monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset2 && instr_valid2 && !stall2) begin
                $display("[%0t] consume2 pc=%01h word=%08h", $time, instr_pc2, Instruccion2);
                if (exp2_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr2: got pc=%01h expected none", instr_pc2);
                end else begin
                    e = exp2_q.pop_front();
                    check("instr_pc2", 32'(instr_pc2), 32'(e.pc));
                    check("instr_word2", Instruccion2, e.word);
                end
            end
        end
    end

    task automatic wait_pc(input logic [9:0] pc, input int bound);
        int n;
        bit found;
        n = 0;
        found = 0;
        while (!found && n < bound) begin
            @(negedge clock);
            n++;
            if (instr_valid && instr_pc == pc) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_pc: got timeout expected instr_pc %03h", pc);
        end
    endtask

    task automatic wait_halted(input int bound);
        int n;
        n = 0;
        while (!halted && n < bound) begin
            @(negedge clock);
            n++;
        end
        check("reach_halt", 32'(halted), 32'd1);
    endtask

    task automatic wait_req(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!imem_req && n < bound);
        check("see_req", 32'(imem_req), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [9:0] target);
        @(posedge clock); #1;
        redirect = 1'b1;
        redirect_pc = target;
        @(posedge clock); #1;
        redirect = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", Instruccion, NOP_INSTR);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0001 + i;
        mem[5]    = HALT_WORD;
        mem[10'h22] = HALT_WORD;
        for (int i = 0; i < 16; i++) mem2[i] = 32'h2000_0000 + i;
        mem2[2] = HALT_WORD;

        reset = 1; stall = 0; redirect = 0; redirect_pc = '0; lat = 1;
        reset2 = 1; stall2 = 0; redirect2 = 0; redirect_pc2 = '0;

        // Small instance: PC wraps 14, 15, 0, 1 then halts at 2.
        push_exp2(10'd14, 32'h2000_000E);
        push_exp2(10'd15, 32'h2000_000F);
        push_exp2(10'd0,  32'h2000_0000);
        push_exp2(10'd1,  32'h2000_0001);
        push_exp2(10'd2,  HALT_WORD);

        // ---- reset state and straight-line fetch 0..5 ----
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_values();
        for (int i = 0; i < 5; i++) push_exp(10'(i), 32'h1000_0001 + i);
        push_exp(10'd5, HALT_WORD);
        @(posedge clock); #1;
        reset = 0;
        reset2 = 0;
        @(negedge clock);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", 32'(imem_addr), 32'd0);
        wait_pc(10'd0, 20);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            check("throughput_valid", 32'(instr_valid), 32'd1);
            check("throughput_pc", 32'(instr_pc), 32'(k));
        end
        @(negedge clock);
        @(posedge clock); #1;
        stall = 1;
        @(negedge clock);
        check("halt_pc", 32'(instr_pc), 32'd5);
        check("halt_word", Instruccion, HALT_WORD);
        check("halted_set", 32'(halted), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("halt_no_req", 32'(imem_req), 32'd0);
        end
        @(posedge clock); #1;
        stall = 0;
        @(negedge clock);
        @(negedge clock);
        check("halt_consumed", 32'(instr_valid), 32'd0);
        check("halted_stays", 32'(halted), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("halt_idle_no_req", 32'(imem_req), 32'd0);
        end
        check("queue_drained_a", 32'(exp_q.size()), 32'd0);

        // ---- stall for 3 cycles while pc 2 is presented ----
        for (int i = 0; i < 5; i++) push_exp(10'(i), 32'h1000_0001 + i);
        push_exp(10'd5, HALT_WORD);
        pulse_redirect(10'd0);
        wait_pc(10'd1, 20);
        @(posedge clock); #1;
        stall = 1;
        @(negedge clock);
        check("stall_pc2", 32'(instr_pc), 32'd2);
        check("stall_word2", Instruccion, 32'h1000_0003);
        repeat (3) @(posedge clock);
        #1;
        stall = 0;
        wait_halted(40);
        repeat (3) @(negedge clock);
        check("queue_drained_b", 32'(exp_q.size()), 32'd0);

        // ---- redirect out of HALT, then squash an in-flight response ----
        lat = 3;
        @(posedge clock); #1;
        stall = 1;
        pulse_redirect(10'd0);
        wait_pc(10'd0, 30);
        check("restart_word", Instruccion, 32'h1000_0001);
        check("restart_not_halted", 32'(halted), 32'd0);
        push_exp(10'h20, 32'h1000_0021);
        push_exp(10'h21, 32'h1000_0022);
        push_exp(10'h22, HALT_WORD);
        @(posedge clock); #1;
        redirect = 1;
        redirect_pc = 10'h20;
        @(posedge clock); #1;
        redirect = 0;
        stall = 0;
        @(negedge clock);
        check("redirect_clears_valid", 32'(instr_valid), 32'd0);
        check("squash_no_req", 32'(imem_req), 32'd0);
        wait_halted(60);
        repeat (3) @(negedge clock);
        check("queue_drained_c", 32'(exp_q.size()), 32'd0);

        // ---- reset while a 3-cycle response is outstanding ----
        pulse_redirect(10'd8);
        wait_req(10);
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_reset_values();
        end
        for (int i = 0; i < 5; i++) push_exp(10'(i), 32'h1000_0001 + i);
        push_exp(10'd5, HALT_WORD);
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        check("post_reset_req", 32'(imem_req), 32'd1);
        check("post_reset_addr", 32'(imem_addr), 32'd0);
        check("post_reset_valid", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("late_rsp_ignored", 32'(instr_valid), 32'd0);
        end
        wait_halted(80);
        repeat (3) @(negedge clock);
        check("queue_drained_d", 32'(exp_q.size()), 32'd0);

        // ---- small instance results ----
        check("wrap_queue_drained", 32'(exp2_q.size()), 32'd0);
        check("wrap_halted", 32'(halted2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
